// File: rtl/mips_pkg.sv
// mips_pkg -- shared constants and types for the instruction-memory loader.
//   IMEM_ADDR_W    : default instruction-memory word-address width (256 words)
//   BYTES_PER_WORD : program bytes per 32-bit instruction word
//   BCNT_W         : width of the byte-within-word counter
//   ldr_state_e    : loader FSM state encoding
package mips_pkg;
    localparam int IMEM_ADDR_W    = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHK   = 3'd3,
        ST_DONE  = 3'd4
    } ldr_state_e;
endpackage

// File: rtl/byte_packer.sv
// byte_packer -- assembles a big-endian byte stream into 32-bit words.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   i_clr         : synchronous clear of counter and partial word (new load)
//   i_en          : a byte transfers this cycle
//   i_byte        : byte being transferred
//   o_word_nxt    : word including the current byte ({held[23:0], i_byte})
//   o_word_ready  : pulse, the current byte completes a word
module byte_packer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word_nxt,
    output logic        o_word_ready
);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

    // Only the three most recent bytes need holding; the fourth is the live input.
    logic [23:0]       r_word;
    logic [BCNT_W-1:0] r_cnt;

    assign o_word_nxt   = {r_word, i_byte};
    assign o_word_ready = i_en && (r_cnt == LAST_BYTE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_en) begin
            r_word <= o_word_nxt[23:0];
            r_cnt  <= r_cnt + BCNT_W'(1);   // wraps 3 -> 0
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader -- loads a byte-serial program image into instruction memory.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to receive a 4-byte trailer
// after the last word and compare it with the 32-bit wrap-around sum of the
// written words (err=1 on mismatch). Without it, err is tied low.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   start, load_len        : begin a load of load_len words (accepted in IDLE/DONE)
//   byte_valid, byte_data  : program byte stream, big-endian within each word
//   byte_ready             : loader accepts a byte this cycle
//   we, waddr, wdata       : instruction-memory write port (one cycle per word)
//   busy, done, err        : status
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    ldr_state_e        r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_wcnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;

    logic              w_start_ok;
    logic              w_byte_en;
    logic [31:0]       w_word_nxt;
    logic              w_word_ready;
    logic [ADDR_W:0]   w_len_clamped;
    logic [ADDR_W:0]   w_wcnt_nxt;

    assign w_start_ok    = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign byte_ready    = (r_state == ST_RECV) || (r_state == ST_CHK);
    assign w_byte_en     = byte_valid && byte_ready;
    assign w_len_clamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    assign w_wcnt_nxt    = r_wcnt + (ADDR_W+1)'(1);

    assign busy  = (r_state == ST_RECV) || (r_state == ST_WRITE) || (r_state == ST_CHK);
    assign done  = (r_state == ST_DONE);
    assign we    = r_we;
    assign waddr = r_waddr;
    assign wdata = r_wdata;

    byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clr        (w_start_ok),
        .i_en         (w_byte_en),
        .i_byte       (byte_data),
        .o_word_nxt   (w_word_nxt),
        .o_word_ready (w_word_ready)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_sum;
    logic        r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_wcnt  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_len   <= w_len_clamped;
                        r_wcnt  <= '0;
                        r_addr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum   <= '0;
                        r_err   <= 1'b0;
`endif
                        r_state <= (load_len == '0) ? ST_DONE : ST_RECV;
                    end
                end
                ST_RECV: begin
                    // Word completes on this byte: register the write so we
                    // pulses in the next cycle while the FSM sits in WRITE.
                    if (w_word_ready) begin
                        r_we    <= 1'b1;
                        r_waddr <= r_addr;
                        r_wdata <= w_word_nxt;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_wcnt <= w_wcnt_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_sum  <= r_sum + r_wdata;
                    r_state <= (w_wcnt_nxt < r_len) ? ST_RECV : ST_CHK;
`else
                    r_state <= (w_wcnt_nxt < r_len) ? ST_RECV : ST_DONE;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (w_word_ready) begin
                        r_err   <= (w_word_nxt != r_sum);
                        r_state <= ST_DONE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- directed self-checking bench for imem_loader.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] load_len;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready, we, busy, done, err;
    logic [7:0] waddr;
    logic [31:0] wdata;

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;

    imem_loader #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Count write strobes seen at each rising edge (pre-update values).
    always @(posedge clk) if (we === 1'b1) we_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [8:0] len);
        start = 1'b1; load_len = len;
        @(negedge clk);
        start = 1'b0; load_len = 9'h000;
    endtask

    // Presents one byte after 'gap' idle cycles; returns at the negedge after
    // the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output logic ok);
        int t;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1; byte_data = b; t = 0;
        while (byte_ready !== 1'b1 && t < 20) begin
            @(negedge clk); t++;
        end
        ok = (t < 20);
        @(negedge clk);
        byte_valid = 1'b0; byte_data = 8'h00;
    endtask

    // Sends n bytes from the top of s. 'skew' is how many bytes of the current
    // word were already sent. Captures we/waddr/wdata one cycle after each
    // word-completing byte, and counts we pulses seen after other bytes.
    task automatic feed(input logic [63:0] s, input int n, input int gap, input int skew,
                        output logic [1:0] w_seen, output logic [7:0] a0, output logic [7:0] a1,
                        output logic [31:0] d0, output logic [31:0] d1,
                        output int stray, output int tmo);
        logic ok;
        int   k;
        w_seen = 2'b00; a0 = '0; a1 = '0; d0 = '0; d1 = '0; stray = 0; tmo = 0;
        for (int i = 0; i < n; i++) begin
            send_byte(s[63-8*i -: 8], gap, ok);
            if (!ok) tmo++;
            k = i + skew;
            if (k % 4 == 3) begin
                if (k / 4 == 0) begin w_seen[0] = we; a0 = waddr; d0 = wdata; end
                else            begin w_seen[1] = we; a1 = waddr; d1 = wdata; end
            end else if (we === 1'b1) begin
                stray++;
            end
        end
    endtask

    logic [1:0]  ws;
    logic [7:0]  a0, a1;
    logic [31:0] d0, d1;
    int          st, tm, c0;

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = '0;
        @(negedge clk);
        tests++;
        if ({byte_ready, we, busy, done, err, waddr, wdata} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy%b we%b busy%b done%b err%b addr%h data%h want all 0",
                     byte_ready, we, busy, done, err, waddr, wdata);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, done, byte_ready} !== 3'b000) begin
            fails++; $display("FAIL reset_idle: got busy%b done%b rdy%b want 000", busy, done, byte_ready);
        end
    endtask

    task automatic test_basic(input int gap, input string tag);
        c0 = we_cnt;
        do_start(9'd2);
        tests++;
        if ({busy, byte_ready, done} !== 3'b110) begin
            fails++; $display("FAIL %s_recv: got busy%b rdy%b done%b want 110", tag, busy, byte_ready, done);
        end
        feed(64'h2001000A_20020014, 8, gap, 0, ws, a0, a1, d0, d1, st, tm);
        tests++;
        if (ws !== 2'b11 || st != 0 || tm != 0) begin
            fails++; $display("FAIL %s_we_timing: got seen=%b stray=%0d tmo=%0d want 11/0/0", tag, ws, st, tm);
        end
        tests++;
        if (a0 !== 8'd0 || d0 !== 32'h2001000A) begin
            fails++; $display("FAIL %s_word0: got %h@%0d want 2001000a@0", tag, d0, a0);
        end
        tests++;
        if (a1 !== 8'd1 || d1 !== 32'h20020014) begin
            fails++; $display("FAIL %s_word1: got %h@%0d want 20020014@1", tag, d1, a1);
        end
        @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
        feed(64'h4003001E_00000000, 4, gap, 0, ws, a0, a1, d0, d1, st, tm);
`endif
        tests++;
        if ({done, busy, err} !== 3'b100 || we_cnt - c0 != 2) begin
            fails++; $display("FAIL %s_done: got done%b busy%b err%b writes=%0d want 100 writes=2",
                              tag, done, busy, err, we_cnt - c0);
        end
    endtask

    task automatic test_len0;
        c0 = we_cnt;
        do_start(9'd0);
        tests++;
        if ({done, busy} !== 2'b10) begin
            fails++; $display("FAIL len0_done: got done%b busy%b want 10", done, busy);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (we_cnt != c0 || done !== 1'b1) begin
            fails++; $display("FAIL len0_nowrite: got writes=%0d done%b want 0 writes done=1", we_cnt - c0, done);
        end
    endtask

    task automatic test_reset_midload;
        do_start(9'd2);
        c0 = we_cnt;
        feed(64'h2001000A_20020000, 6, 0, 0, ws, a0, a1, d0, d1, st, tm);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({we, busy, done, byte_ready} !== 4'b0000 || waddr !== 8'd0 || wdata !== 32'd0) begin
            fails++; $display("FAIL midrst_outputs: got we%b busy%b done%b rdy%b addr%h data%h want 0",
                              we, busy, done, byte_ready, waddr, wdata);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (we_cnt - c0 != 1) begin
            fails++; $display("FAIL midrst_partial: got writes=%0d want 1", we_cnt - c0);
        end
        do_start(9'd1);
        c0 = we_cnt;
        feed(64'hAC030004_00000000, 4, 0, 0, ws, a0, a1, d0, d1, st, tm);
        tests++;
        if (ws[0] !== 1'b1 || a0 !== 8'd0 || d0 !== 32'hAC030004 || st != 0 || tm != 0) begin
            fails++; $display("FAIL midrst_reload: got we%b %h@%0d stray=%0d tmo=%0d want 1 ac030004@0",
                              ws[0], d0, a0, st, tm);
        end
        @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
        feed(64'hAC030004_00000000, 4, 0, 0, ws, a0, a1, d0, d1, st, tm);
`endif
        tests++;
        if (done !== 1'b1 || we_cnt - c0 != 1) begin
            fails++; $display("FAIL midrst_single: got done%b writes=%0d want 1 1", done, we_cnt - c0);
        end
    endtask

    task automatic test_start_ignored;
        c0 = we_cnt;
        do_start(9'd2);
        feed(64'h20010000_00000000, 2, 0, 0, ws, a0, a1, d0, d1, st, tm);
        start = 1'b1; load_len = 9'd1;
        @(negedge clk);
        start = 1'b0; load_len = 9'd0;
        tests++;
        if ({busy, done, byte_ready} !== 3'b101) begin
            fails++; $display("FAIL ign_state: got busy%b done%b rdy%b want 101", busy, done, byte_ready);
        end
        feed(64'h000A2002_00140000, 6, 0, 2, ws, a0, a1, d0, d1, st, tm);
        tests++;
        if (ws !== 2'b11 || d0 !== 32'h2001000A || d1 !== 32'h20020014 || a1 !== 8'd1 || tm != 0) begin
            fails++; $display("FAIL ign_words: got seen=%b %h %h@%0d tmo=%0d want 11 2001000a 20020014@1",
                              ws, d0, d1, a1, tm);
        end
        @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
        feed(64'h4003001E_00000000, 4, 0, 0, ws, a0, a1, d0, d1, st, tm);
`endif
        tests++;
        if (done !== 1'b1 || we_cnt - c0 != 2) begin
            fails++; $display("FAIL ign_done: got done%b writes=%0d want 1 2", done, we_cnt - c0);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum_bad;
        do_start(9'd2);
        feed(64'h2001000A_20020014, 8, 0, 0, ws, a0, a1, d0, d1, st, tm);
        @(negedge clk);
        tests++;
        if ({busy, byte_ready, done} !== 3'b110) begin
            fails++; $display("FAIL chk_state: got busy%b rdy%b done%b want 110", busy, byte_ready, done);
        end
        c0 = we_cnt;
        feed(64'h4003001F_00000000, 4, 1, 0, ws, a0, a1, d0, d1, st, tm);
        tests++;
        if ({done, err} !== 2'b11 || we_cnt != c0 || ws[0] !== 1'b0 || st != 0) begin
            fails++; $display("FAIL chk_bad: got done%b err%b extra_writes=%0d want 11 0", done, err, we_cnt - c0);
        end
        do_start(9'd0);
        tests++;
        if ({done, err} !== 2'b10) begin
            fails++; $display("FAIL chk_errclr: got done%b err%b want 10", done, err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic(0, "basic");
        test_basic(3, "gaps");
        test_len0();
        test_reset_midload();
        test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
